pipeline_decode_stage: RTL

- Parametrised successor to the current register-address-only decode stage.
- Decodes one instruction per cycle into register addresses and a full control bundle, and holds them in an ID/EX output register.
- Uses a valid/ready handshake upstream and downstream, a load-use interlock that inserts exactly one bubble, a flush input, and a saturating bubble counter.
- Sits between the instruction-fetch register and the execute stage.

---
 rtl/pipeline_decode_stage_pkg.sv | 38 +++
 rtl/pipeline_decode_stage_if.sv | 41 ++++
 rtl/pipeline_decode_stage_decode_control_table.sv | 83 ++++++++
 rtl/pipeline_decode_stage.sv | 120 ++++++++++++
 4 files changed

// File: rtl/pipeline_decode_stage_pkg.sv
// Shared opcodes, control encodings and the decoded control bundle for the decode stage.
package pipeline_decode_stage_pkg;

  localparam logic [3:0] OP_SUM     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_AND     = 4'b0010;
  localparam logic [3:0] OP_NOT     = 4'b0011;
  localparam logic [3:0] OP_COND    = 4'b1011;
  localparam logic [3:0] OP_STORE   = 4'b1100;
  localparam logic [3:0] OP_LOAD    = 4'b1101;
  localparam logic [3:0] OP_COPY    = 4'b1110;
  localparam logic [3:0] OP_COPY_IN = 4'b1111;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_OR  = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    MUX_NONE = 3'b000,
    MUX_MEM  = 3'b001,
    MUX_IN   = 3'b010,
    MUX_ALU  = 3'b011,
    MUX_RF   = 3'b100
  } mux_sel_e;

  typedef struct packed {
    logic     write_enable;
    alu_op_e  control_alu;
    mux_sel_e control_mux;
    logic     mem_read;
    logic     mem_write;
    logic     cond_copy;
  } ctrl_t;

endpackage

// File: rtl/pipeline_decode_stage_if.sv
// Upstream/downstream handshake and decoded ID/EX bundle of the decode stage.
interface pipeline_decode_stage_if #(
  parameter int INSTR_W    = 20,
  parameter int OPCODE_W   = 4,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [INSTR_W-1:0]    instruction;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [OPCODE_W-1:0]   opcode_out;
  logic [REG_ADDR_W-1:0] write_address;
  logic                  write_enable;
  logic [REG_ADDR_W-1:0] read_address_rf1;
  logic [REG_ADDR_W-1:0] read_address_rf2;
  logic [1:0]            control_alu;
  logic [2:0]            control_mux;
  logic                  mem_read;
  logic                  mem_write;
  logic                  cond_copy;
  logic [CNT_W-1:0]      bubble_count;

  // Environment side: fetch register upstream plus execute stage downstream.
  modport master (
    output in_valid, instruction, flush, out_ready,
    input  in_ready, out_valid, opcode_out, write_address, write_enable,
           read_address_rf1, read_address_rf2, control_alu, control_mux,
           mem_read, mem_write, cond_copy, bubble_count
  );

  // Decode stage side.
  modport slave (
    input  in_valid, instruction, flush, out_ready,
    output in_ready, out_valid, opcode_out, write_address, write_enable,
           read_address_rf1, read_address_rf2, control_alu, control_mux,
           mem_read, mem_write, cond_copy, bubble_count
  );
endinterface

// File: rtl/pipeline_decode_stage_decode_control_table.sv
// Pure combinational opcode decoder: register addresses, control bundle and read-use flags.
module decode_control_table
  import pipeline_decode_stage_pkg::*;
#(
  parameter int OPCODE_W   = 4,
  parameter int REG_ADDR_W = 4
) (
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [REG_ADDR_W-1:0] field_a,
  input  logic [REG_ADDR_W-1:0] field_b,
  input  logic [REG_ADDR_W-1:0] field_c,
  output logic [REG_ADDR_W-1:0] rf1,
  output logic [REG_ADDR_W-1:0] rf2,
  output logic [REG_ADDR_W-1:0] write_address,
  output ctrl_t                 ctrl,
  output logic                  use_rf1,
  output logic                  use_rf2
);

  // Unknown opcodes fall through as no-ops reading B/C with every enable low.
  always_comb begin
    rf1           = field_b;
    rf2           = field_c;
    write_address = '0;
    ctrl          = '0;
    use_rf1       = 1'b0;
    use_rf2       = 1'b0;
    case (opcode)
      OPCODE_W'(OP_STORE): begin
        rf1            = field_a;
        rf2            = field_b;
        ctrl.mem_write = 1'b1;
        use_rf1        = 1'b1;
        use_rf2        = 1'b1;
      end
      OPCODE_W'(OP_LOAD): begin
        write_address     = field_a;
        ctrl.write_enable = 1'b1;
        ctrl.control_mux  = MUX_MEM;
        ctrl.mem_read     = 1'b1;
        use_rf1           = 1'b1;
        use_rf2           = 1'b1;
      end
      OPCODE_W'(OP_COND): begin
        write_address     = field_a;
        ctrl.write_enable = 1'b1;
        ctrl.control_mux  = MUX_RF;
        ctrl.cond_copy    = 1'b1;
        use_rf1           = 1'b1;
        use_rf2           = 1'b1;
      end
      OPCODE_W'(OP_COPY_IN): begin
        write_address     = field_a;
        ctrl.write_enable = 1'b1;
        ctrl.control_mux  = MUX_IN;
      end
      OPCODE_W'(OP_COPY): begin
        write_address     = field_a;
        ctrl.write_enable = 1'b1;
        ctrl.control_mux  = MUX_RF;
        use_rf1           = 1'b1;
      end
      OPCODE_W'(OP_SUM), OPCODE_W'(OP_OR), OPCODE_W'(OP_AND): begin
        write_address     = field_a;
        ctrl.write_enable = 1'b1;
        ctrl.control_mux  = MUX_ALU;
        ctrl.control_alu  = (opcode == OPCODE_W'(OP_SUM)) ? ALU_ADD :
                            (opcode == OPCODE_W'(OP_OR))  ? ALU_OR  : ALU_AND;
        use_rf1           = 1'b1;
        use_rf2           = 1'b1;
      end
      OPCODE_W'(OP_NOT): begin
        write_address     = field_a;
        ctrl.write_enable = 1'b1;
        ctrl.control_mux  = MUX_ALU;
        ctrl.control_alu  = ALU_NOT;
        use_rf1           = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_decode_stage.sv
// Decode stage: valid/ready handshake, load-use interlock, flush and ID/EX output register.
module pipeline_decode_stage
  import pipeline_decode_stage_pkg::*;
#(
  parameter int INSTR_W    = 20,
  parameter int OPCODE_W   = 4,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input logic                    clock,
  input logic                    reset,
  pipeline_decode_stage_if.slave bus
);

  localparam int A_MSB = INSTR_W - OPCODE_W - 1;
  localparam int B_MSB = A_MSB - REG_ADDR_W;
  localparam int C_MSB = B_MSB - REG_ADDR_W;

  logic [OPCODE_W-1:0]   opcode;
  logic [REG_ADDR_W-1:0] field_a, field_b, field_c;
  logic [REG_ADDR_W-1:0] dec_rf1, dec_rf2, dec_write_address;
  ctrl_t                 dec_ctrl;
  logic                  use_rf1, use_rf2;

  logic                  out_valid_q;
  logic [OPCODE_W-1:0]   opcode_q;
  logic [REG_ADDR_W-1:0] write_address_q, rf1_q, rf2_q;
  ctrl_t                 ctrl_q;
  logic                  last_load;
  logic [REG_ADDR_W-1:0] last_dest;
  logic [CNT_W-1:0]      bubble_q;

  logic advance, hazard, in_ready_c, accept;
  logic unused_instruction_parity;

  assign opcode  = bus.instruction[INSTR_W-1 -: OPCODE_W];
  assign field_a = bus.instruction[A_MSB -: REG_ADDR_W];
  assign field_b = bus.instruction[B_MSB -: REG_ADDR_W];
  assign field_c = bus.instruction[C_MSB -: REG_ADDR_W];

  // Trailing instruction bits beyond field C carry nothing for this stage.
  assign unused_instruction_parity = ^bus.instruction;

  decode_control_table #(
    .OPCODE_W  (OPCODE_W),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_table (
    .opcode       (opcode),
    .field_a      (field_a),
    .field_b      (field_b),
    .field_c      (field_c),
    .rf1          (dec_rf1),
    .rf2          (dec_rf2),
    .write_address(dec_write_address),
    .ctrl         (dec_ctrl),
    .use_rf1      (use_rf1),
    .use_rf2      (use_rf2)
  );

  assign advance = !out_valid_q || bus.out_ready;
  assign hazard  = bus.in_valid && last_load &&
                   ((use_rf1 && (dec_rf1 == last_dest)) ||
                    (use_rf2 && (dec_rf2 == last_dest)));
  assign in_ready_c = advance && !hazard && !bus.flush && reset;
  assign accept     = bus.in_valid && in_ready_c;

  // ID/EX register plus interlock state; flush beats hazard and accept, stall holds everything.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q     <= 1'b0;
      opcode_q        <= '0;
      write_address_q <= '0;
      rf1_q           <= '0;
      rf2_q           <= '0;
      ctrl_q          <= '0;
      last_load       <= 1'b0;
      last_dest       <= '0;
      bubble_q        <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      last_load   <= 1'b0;
    end else if (advance) begin
      if (accept) begin
        out_valid_q     <= 1'b1;
        opcode_q        <= opcode;
        write_address_q <= dec_write_address;
        rf1_q           <= dec_rf1;
        rf2_q           <= dec_rf2;
        ctrl_q          <= dec_ctrl;
        last_load       <= dec_ctrl.mem_read;
        if (dec_ctrl.mem_read) begin
          last_dest <= field_a;
        end
      end else if (hazard) begin
        out_valid_q <= 1'b0;
        last_load   <= 1'b0;
        if (bubble_q != '1) begin
          bubble_q <= bubble_q + CNT_W'(1);
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready         = in_ready_c;
  assign bus.out_valid        = out_valid_q;
  assign bus.opcode_out       = opcode_q;
  assign bus.write_address    = write_address_q;
  assign bus.write_enable     = ctrl_q.write_enable;
  assign bus.read_address_rf1 = rf1_q;
  assign bus.read_address_rf2 = rf2_q;
  assign bus.control_alu      = ctrl_q.control_alu;
  assign bus.control_mux      = ctrl_q.control_mux;
  assign bus.mem_read         = ctrl_q.mem_read;
  assign bus.mem_write        = ctrl_q.mem_write;
  assign bus.cond_copy        = ctrl_q.cond_copy;
  assign bus.bubble_count     = bubble_q;

endmodule
